// File: rtl/core_pkg.sv
// Shared core constants: sequencer state codes, decoder opcodes, widths.
// Imported by the sequencer, its interface users and the decoder.
package core_pkg;

  localparam int OPCODE_W   = 7;
  localparam int REG_ADDR_W = 3;

  localparam logic [OPCODE_W-1:0] OP_HLT = 7'b1100001;
  localparam logic [OPCODE_W-1:0] OP_LDD = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_NOP = 7'b0010011;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DRAIN_H  = 3'd1,
    ST_HALT     = 3'd2,
    ST_DRAIN_I  = 3'd3,
    ST_INTR_VEC = 3'd4
  } seq_state_e;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Decoder/sequencer bundle: ID/EX hazard inputs, interrupt, stage controls.
// master = decoder/pipeline side, slave = pipe_sequencer.
interface pipe_sequencer_if #(
  parameter int OPCODE_W   = 7,
  parameter int REG_ADDR_W = 3
);

  logic [OPCODE_W-1:0]   id_opcode;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_uses_src2;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  intr;

  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  epc_capture;
  logic                  pc_sel_intr;
  logic                  intr_ack;
  logic                  halted;
  logic [2:0]            seq_state;

  modport master (
    output id_opcode, id_src1, id_src2,
    output id_uses_src2, ex_is_load, ex_dst, intr,
    input  pc_en, ifid_en, ifid_flush,
    input  idex_bubble, epc_capture,
    input  pc_sel_intr, intr_ack, halted,
    input  seq_state
  );

  modport slave (
    input  id_opcode, id_src1, id_src2,
    input  id_uses_src2, ex_is_load, ex_dst, intr,
    output pc_en, ifid_en, ifid_flush,
    output idex_bubble, epc_capture,
    output pc_sel_intr, intr_ack, halted,
    output seq_state
  );

endinterface

// File: rtl/pipe_sequencer_load_use_detect.sv
// Load-use comparator: EX load whose dst feeds a source of the ID instr.
// Ports: ex_is_load/ex_dst, id_src1/id_src2/id_uses_src2 in; hazard out.
module load_use_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_uses_src2,
  output logic                  hazard
);

  logic hit1;
  logic hit2;

  assign hit1   = (ex_dst == id_src1);
  assign hit2   = id_uses_src2 & (ex_dst == id_src2);
  assign hazard = ex_is_load & (hit1 | hit2);

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: load-use stalls, HLT drain/freeze, interrupt entry.
// Ports: clk, reset (sync, active-high), bus (slave) with stage controls.
module pipe_sequencer #(
  parameter int                 OPCODE_W     = 7,
  parameter int                 REG_ADDR_W   = 3,
  parameter int                 DRAIN_CYCLES = 3,
  parameter logic [OPCODE_W-1:0] HLT_OPCODE  = 7'b1100001
) (
  input  logic             clk,
  input  logic             reset,
  pipe_sequencer_if.slave  bus
);

  import core_pkg::*;

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             intr_pending_q, intr_pending_d;

  logic hazard;
  logic take_intr;
  logic is_hlt;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lud (
    .ex_is_load   (bus.ex_is_load),
    .ex_dst       (bus.ex_dst),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .id_uses_src2 (bus.id_uses_src2),
    .hazard       (hazard)
  );

  assign take_intr = bus.intr | intr_pending_q;
  assign is_hlt    = (bus.id_opcode == HLT_OPCODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      intr_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      intr_pending_q <= intr_pending_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    intr_pending_d = intr_pending_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.intr) intr_pending_d = 1'b1;
        if (hazard) begin
          state_d = ST_RUN;
        end else if (take_intr) begin
          state_d = ST_DRAIN_I;
          cnt_d   = CNT_LOAD;
        end else if (is_hlt) begin
          state_d = ST_DRAIN_H;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DRAIN_H: begin
        if (bus.intr) intr_pending_d = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (take_intr) state_d = ST_INTR_VEC;
      end
      ST_DRAIN_I: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = ST_INTR_VEC;
      end
      ST_INTR_VEC: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // A request is consumed as soon as the vector cycle is entered.
    if (state_d == ST_INTR_VEC) intr_pending_d = 1'b0;
  end

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.epc_capture = 1'b0;
    bus.pc_sel_intr = 1'b0;
    bus.intr_ack    = 1'b0;
    bus.halted      = 1'b0;
    bus.seq_state   = state_q;
    if (reset) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
      bus.seq_state   = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          bus.pc_en   = 1'b1;
          bus.ifid_en = 1'b1;
          if (hazard) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_bubble = 1'b1;
          end else if (take_intr) begin
            bus.pc_en       = 1'b0;
            bus.epc_capture = 1'b1;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
          end else if (is_hlt) begin
            // HLT itself moves on to EX; only the fetch behind it dies.
            bus.pc_en      = 1'b0;
            bus.ifid_flush = 1'b1;
          end
        end
        ST_DRAIN_H, ST_DRAIN_I: begin
          bus.idex_bubble = 1'b1;
        end
        ST_HALT: begin
          bus.halted      = 1'b1;
          bus.idex_bubble = 1'b1;
        end
        ST_INTR_VEC: begin
          bus.pc_sel_intr = 1'b1;
          bus.pc_en       = 1'b1;
          bus.intr_ack    = 1'b1;
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
        end
        default: begin
          bus.idex_bubble = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Testbench for pipe_sequencer: directed scenarios plus random traffic
// scored against a cycle-count reference model of the sequencing rules.
module tb_pipe_sequencer;

  import core_pkg::*;

  localparam int D = 3;

  // {pc_en, ifid_en, ifid_flush, idex_bubble,
  //  epc_capture, pc_sel_intr, intr_ack, halted}
  localparam logic [7:0] RSTV  = 8'b0011_0000;
  localparam logic [7:0] RUNV  = 8'b1100_0000;
  localparam logic [7:0] STALL = 8'b0001_0000;
  localparam logic [7:0] INTRC = 8'b0111_1000;
  localparam logic [7:0] HLTV  = 8'b0110_0000;
  localparam logic [7:0] DRN   = 8'b0001_0000;
  localparam logic [7:0] HALTV = 8'b0001_0001;
  localparam logic [7:0] VECV  = 8'b1011_0110;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_sequencer_if bus ();

  pipe_sequencer #(
    .DRAIN_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  function automatic logic [7:0] outs();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush,
            bus.idex_bubble, bus.epc_capture,
            bus.pc_sel_intr, bus.intr_ack, bus.halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op,
                       input logic [2:0] s1,
                       input logic [2:0] s2,
                       input logic       u2,
                       input logic       ld,
                       input logic [2:0] dst,
                       input logic       ir);
    bus.id_opcode    = op;
    bus.id_src1      = s1;
    bus.id_src2      = s2;
    bus.id_uses_src2 = u2;
    bus.ex_is_load   = ld;
    bus.ex_dst       = dst;
    bus.intr         = ir;
  endtask

  task automatic idle(input logic ir);
    drive(OP_NOP, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, ir);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(1'b0);
    #4;
    checks++;
    if (outs() !== RSTV || bus.seq_state !== 3'd0)
      $display("FAIL reset outs=%b st=%0d want=%b st=0",
               outs(), bus.seq_state, RSTV);
    else passed++;
    tick();
    reset = 1'b0;
    #4;
    checks++;
    if (outs() !== RUNV || bus.seq_state !== 3'd0)
      $display("FAIL post_reset outs=%b st=%0d want=%b st=0",
               outs(), bus.seq_state, RUNV);
    else passed++;
    tick();
  endtask

  task automatic test_hazard();
    logic [7:0] ev [3];
    ev = '{STALL, RUNV, STALL};
    for (int i = 0; i < 3; i++) begin
      unique case (i)
        0: drive(OP_NOP, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0);
        1: drive(OP_NOP, 3'd5, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0);
        default: drive(OP_NOP, 3'd5, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0);
      endcase
      #4;
      checks++;
      if (outs() !== ev[i] || bus.seq_state !== 3'd0)
        $display("FAIL hazard[%0d] outs=%b want=%b", i, outs(), ev[i]);
      else passed++;
      tick();
    end
    idle(1'b0);
  endtask

  task automatic test_halt();
    logic [7:0] e;
    logic [2:0] es;
    for (int i = 0; i < 25; i++) begin
      if (i == 0) drive(OP_HLT, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
      else idle(1'b0);
      e  = (i == 0) ? HLTV : (i <= D) ? DRN : HALTV;
      es = (i == 0) ? 3'd0 : (i <= D) ? 3'd1 : 3'd2;
      #4;
      checks++;
      if (outs() !== e || bus.seq_state !== es)
        $display("FAIL halt c%0d outs=%b st=%0d want=%b st=%0d",
                 i, outs(), bus.seq_state, e, es);
      else passed++;
      tick();
    end
  endtask

  task automatic test_halt_intr();
    logic [7:0] ev [3];
    logic [2:0] es [3];
    ev = '{HALTV, VECV, RUNV};
    es = '{3'd2, 3'd4, 3'd0};
    for (int i = 0; i < 3; i++) begin
      idle(i == 0);
      #4;
      checks++;
      if (outs() !== ev[i] || bus.seq_state !== es[i])
        $display("FAIL halt_intr c%0d outs=%b want=%b",
                 i, outs(), ev[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_intr();
    logic [7:0] ev [6];
    logic [2:0] es [6];
    ev = '{INTRC, DRN, DRN, DRN, VECV, RUNV};
    es = '{3'd0, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 6; i++) begin
      // A second request during the vector cycle must be dropped.
      idle(i == 0 || i == 4);
      #4;
      checks++;
      if (outs() !== ev[i] || bus.seq_state !== es[i])
        $display("FAIL intr c%0d outs=%b st=%0d want=%b st=%0d",
                 i, outs(), bus.seq_state, ev[i], es[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_intr_hazard();
    logic [7:0] ev [7];
    ev = '{STALL, INTRC, DRN, DRN, DRN, VECV, RUNV};
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive(OP_NOP, 3'd4, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1);
      else idle(1'b0);
      #4;
      checks++;
      if (outs() !== ev[i])
        $display("FAIL intr_hazard c%0d outs=%b want=%b",
                 i, outs(), ev[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] e;
    for (int i = 0; i < 10; i++) begin
      idle(i == 0);
      reset = (i == 2);
      e = (i == 0) ? INTRC : (i == 1) ? DRN :
          (i == 2) ? RSTV : RUNV;
      #4;
      checks++;
      if (outs() !== e || bus.seq_state !== ((i == 1) ? 3'd3 : 3'd0))
        $display("FAIL reset_drain c%0d outs=%b st=%0d want=%b",
                 i, outs(), bus.seq_state, e);
      else passed++;
      tick();
    end
    reset = 1'b0;
  endtask

  // Reference: mode 0 run, 1 halting, 2 halted, 3 servicing, 4 vector.
  task automatic test_random();
    int         mode;
    int         left;
    bit         pend;
    bit         rst, ir, ld, u2, hz;
    logic [6:0] op;
    logic [2:0] s1, s2, dst;
    logic [7:0] e;
    int         nerr;
    mode = 0;
    left = 0;
    pend = 0;
    nerr = 0;
    for (int c = 0; c < 800; c++) begin
      rst = (c == 0) || ($urandom_range(0, 63) == 0);
      ir  = ($urandom_range(0, 14) == 0);
      ld  = ($urandom_range(0, 2) == 0);
      u2  = $urandom_range(0, 1) == 1;
      s1  = 3'($urandom_range(0, 7));
      s2  = 3'($urandom_range(0, 7));
      dst = 3'($urandom_range(0, 7));
      op  = ($urandom_range(0, 7) == 0) ? OP_HLT
                                        : 7'($urandom_range(0, 127));
      reset = rst;
      drive(op, s1, s2, u2, ld, dst, ir);
      hz = ld && (dst == s1 || (u2 && dst == s2));
      #4;
      e = RUNV;
      if (rst) begin
        e = RSTV;
        checks++;
        if (outs() !== e || bus.seq_state !== 3'd0)
          $display("FAIL rand_reset c%0d outs=%b want=%b",
                   c, outs(), e);
        else passed++;
        mode = 0;
        pend = 0;
      end else begin
        checks++;
        if (mode == 0) begin
          if (hz) e = STALL;
          else if (ir || pend) e = INTRC;
          else if (op == OP_HLT) e = HLTV;
        end else if (mode == 2) e = HALTV;
        else if (mode == 4) e = VECV;
        else e = DRN;
        if (outs() !== e || int'(bus.seq_state) != mode) begin
          if (nerr < 10)
            $display("FAIL rand c%0d outs=%b st=%0d want=%b st=%0d",
                     c, outs(), bus.seq_state, e, mode);
          nerr++;
        end else passed++;
        case (mode)
          0: begin
            if (ir) pend = 1;
            if (!hz && (ir || pend)) begin
              mode = 3;
              left = D;
            end else if (!hz && op == OP_HLT) begin
              mode = 1;
              left = D;
            end
          end
          1: begin
            if (ir) pend = 1;
            left--;
            if (left == 0) mode = 2;
          end
          2: if (ir || pend) begin
            mode = 4;
            pend = 0;
          end
          3: begin
            left--;
            if (left == 0) begin
              mode = 4;
              pend = 0;
            end
          end
          default: mode = 0;
        endcase
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_halt();
    test_halt_intr();
    test_intr();
    test_intr_hazard();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
